sram_bank_array_ctrl: RTL and testbench

- Parametrised controller that builds one logical single-port RAM from 2^(ADDR_W-ROW_W) identical OpenRAM-style macros.
- Provides a valid/ready request port, a read-response port and per-byte write masks.
- Optionally zero-fills every macro after reset, so tag and valid arrays start clean.
- Sits between the cache/scratchpad arrays and the SRAM macro ring; its generalised bank decode and read mux serve data, tag and scratchpad arrays of any width and depth.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_rdata_mux.sv | 19 +
 rtl/sram_bank_array_ctrl.sv | 130 +++++++++++++
 tb/tb_sram_bank_array_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the banked SRAM controller.
// Bank count derivation and one-hot bank decode live here so every array flavour agrees.
package sram_ctrl_pkg;

  typedef enum logic {ST_INIT, ST_RUN} ctrl_state_t;

  localparam int MAX_NBANK = 16;

  function automatic int nbank(input int addr_w, input int row_w);
    return 1 << (addr_w - row_w);
  endfunction

  // Out-of-range bank numbers decode to no select at all.
  function automatic logic [MAX_NBANK-1:0] bank_onehot(input logic [3:0] addr_hi, input int n);
    logic [MAX_NBANK-1:0] oh;
    oh = '0;
    if (int'(addr_hi) < n) oh[addr_hi] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sram_rdata_mux.sv
// One-hot NBANK:1 read-data mux over the flattened macro outputs.
// Yields zero when no select bit is set.
module sram_rdata_mux #(
  parameter int DATA_W = 32,
  parameter int NBANK  = 8
) (
  input  logic [NBANK-1:0]        sel,
  input  logic [NBANK*DATA_W-1:0] din,
  output logic [DATA_W-1:0]       dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (sel[k]) dout = dout | din[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/sram_bank_array_ctrl.sv
// Builds one logical single-port RAM from 2^(ADDR_W-ROW_W) identical SRAM macros,
// with an optional zero-fill sweep after reset and an optional read output register.
module sram_bank_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int ROW_W     = 9,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1,
  localparam int NBANK    = nbank(ADDR_W, ROW_W),
  localparam int MASK_W   = DATA_W / 8
) (
  input  logic                    RW0_clk,
  input  logic                    RW0_reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [MASK_W-1:0]       req_wmask,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    init_done,
  output logic [NBANK-1:0]        ram_csb,
  output logic                    ram_web,
  output logic [MASK_W-1:0]       ram_wmask,
  output logic [ROW_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  input  logic [NBANK*DATA_W-1:0] ram_dout
);

  ctrl_state_t           state, next_state;
  logic [ROW_W-1:0]      row_cnt;
  logic [NBANK-1:0]      sel_q;
  logic                  rd_q;
  logic [3:0]            addr_hi;
  logic [MAX_NBANK-1:0]  oh_full;
  logic [NBANK-1:0]      req_sel;
  logic                  accept;
  logic                  rd_accept;
  logic [DATA_W-1:0]     mux_data;

  generate
    if (ADDR_W > ROW_W) begin : g_hi
      assign addr_hi = 4'(req_addr[ADDR_W-1:ROW_W]);
    end else begin : g_nohi
      assign addr_hi = '0;
    end
  endgenerate

  assign oh_full   = bank_onehot(addr_hi, NBANK);
  assign req_sel   = oh_full[NBANK-1:0];
  assign req_ready = (state == ST_RUN) && !RW0_reset;
  assign init_done = (state == ST_RUN) && !RW0_reset;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;

  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      state   <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      row_cnt <= '0;
      sel_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state   <= next_state;
      if (state == ST_INIT) row_cnt <= row_cnt + 1'b1;
      sel_q   <= rd_accept ? req_sel : '0;
      rd_q    <= rd_accept;
    end
  end

  always_comb begin
    next_state = state;
    if (state == ST_INIT && (&row_cnt)) next_state = ST_RUN;
  end

  // Macro pins are quiet during reset regardless of the state register.
  always_comb begin
    ram_csb   = '1;
    ram_web   = 1'b1;
    ram_wmask = '0;
    ram_din   = '0;
    ram_addr  = '0;
    if (!RW0_reset) begin
      if (state == ST_INIT) begin
        ram_csb   = '0;
        ram_web   = 1'b0;
        ram_wmask = '1;
        ram_addr  = row_cnt;
      end else if (accept) begin
        ram_csb  = ~req_sel;
        ram_web  = ~req_write;
        ram_addr = req_addr[ROW_W-1:0];
        if (req_write) begin
          ram_wmask = req_wmask;
          ram_din   = req_wdata;
        end
      end
    end
  end

  sram_rdata_mux #(.DATA_W(DATA_W), .NBANK(NBANK)) u_rdata_mux (
    .sel  (sel_q),
    .din  (ram_dout),
    .dout (mux_data)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              out_valid_q;
      logic [DATA_W-1:0] out_data_q;
      always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= rd_q;
          out_data_q  <= mux_data;
        end
      end
      assign resp_valid = out_valid_q && !RW0_reset;
      assign resp_rdata = RW0_reset ? '0 : out_data_q;
    end else begin : g_no_out_reg
      assign resp_valid = rd_q && !RW0_reset;
      assign resp_rdata = RW0_reset ? '0 : mux_data;
    end
  endgenerate

endmodule

// File: tb/tb_sram_bank_array_ctrl.sv
// Directed bench for sram_bank_array_ctrl: default config with a macro model,
// an OUT_REG=1 instance, and a 4-bank 64-bit INIT_ZERO=0 instance.
module tb_sram_bank_array_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic        reqValid = 1'b0, reqWrite = 1'b0;
  logic [11:0] reqAddr = '0;
  logic [3:0]  reqWmask = '0;
  logic [31:0] reqWdata = '0;
  logic [10:0] reqAddr2 = '0;
  logic [7:0]  reqWmask2 = '0;
  logic [63:0] reqWdata2 = '0;

  int nCompared = 0;
  int nMismatched = 0;

  // Instance 0: defaults, backed by a behavioural macro model
  logic        reqReady0, respValid0, initDone0, web0;
  logic [31:0] respRdata0, din0;
  logic [7:0]  csb0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [255:0] dout0;
  logic [31:0] mem0 [8][512];
  logic [31:0] dq0 [8];

  sram_bank_array_ctrl dut0 (
    .RW0_clk(clk), .RW0_reset(rst0),
    .req_valid(reqValid), .req_ready(reqReady0), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wmask(reqWmask), .req_wdata(reqWdata),
    .resp_valid(respValid0), .resp_rdata(respRdata0), .init_done(initDone0),
    .ram_csb(csb0), .ram_web(web0), .ram_wmask(wmask0), .ram_addr(addr0),
    .ram_din(din0), .ram_dout(dout0)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (!csb0[k]) begin
        if (!web0) begin
          for (int b = 0; b < 4; b++)
            if (wmask0[b]) mem0[k][addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end else begin
          dq0[k] <= mem0[k][addr0];
        end
      end
    end
  end

  always_comb begin
    dout0 = '0;
    for (int k = 0; k < 8; k++) dout0[k*32 +: 32] = dq0[k];
  end

  // Instance 1: OUT_REG=1, each bank returns a fixed tag pattern
  logic        reqReady1, respValid1, initDone1, web1;
  logic [31:0] respRdata1, din1;
  logic [7:0]  csb1;
  logic [3:0]  wmask1;
  logic [8:0]  addr1;
  logic [255:0] dout1;

  always_comb begin
    dout1 = '0;
    for (int k = 0; k < 8; k++) dout1[k*32 +: 32] = 32'hC0DE_0000 | 32'(k);
  end

  sram_bank_array_ctrl #(.OUT_REG(1)) dut1 (
    .RW0_clk(clk), .RW0_reset(rst1),
    .req_valid(reqValid), .req_ready(reqReady1), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wmask(reqWmask), .req_wdata(reqWdata),
    .resp_valid(respValid1), .resp_rdata(respRdata1), .init_done(initDone1),
    .ram_csb(csb1), .ram_web(web1), .ram_wmask(wmask1), .ram_addr(addr1),
    .ram_din(din1), .ram_dout(dout1)
  );

  // Instance 2: 4 banks, 64-bit, no zero-fill
  logic        reqReady2, respValid2, initDone2, web2;
  logic [63:0] respRdata2, din2;
  logic [3:0]  csb2;
  logic [7:0]  wmask2;
  logic [8:0]  addr2;
  logic [255:0] dout2;

  always_comb begin
    dout2 = '0;
    for (int k = 0; k < 4; k++) dout2[k*64 +: 64] = 64'hFEED_0000_0000_0000 | 64'(k);
  end

  sram_bank_array_ctrl #(.DATA_W(64), .ADDR_W(11), .INIT_ZERO(0)) dut2 (
    .RW0_clk(clk), .RW0_reset(rst2),
    .req_valid(reqValid), .req_ready(reqReady2), .req_write(reqWrite),
    .req_addr(reqAddr2), .req_wmask(reqWmask2), .req_wdata(reqWdata2),
    .resp_valid(respValid2), .resp_rdata(respRdata2), .init_done(initDone2),
    .ram_csb(csb2), .ram_web(web2), .ram_wmask(wmask2), .ram_addr(addr2),
    .ram_din(din2), .ram_dout(dout2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advances to the next cycle, then drives the request and lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic w, input logic [11:0] a,
                               input logic [7:0] m, input logic [63:0] d);
    @(posedge clk);
    #1;
    reqValid  = v;
    reqWrite  = w;
    reqAddr   = a;
    reqAddr2  = a[10:0];
    reqWmask  = m[3:0];
    reqWmask2 = m;
    reqWdata  = d[31:0];
    reqWdata2 = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int n;

    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("rst_req_ready", 64'(reqReady0), 64'h0);
    checkOutput("rst_resp_valid", 64'(respValid0), 64'h0);
    checkOutput("rst_resp_rdata", 64'(respRdata0), 64'h0);
    checkOutput("rst_init_done", 64'(initDone0), 64'h0);
    checkOutput("rst_csb", 64'(csb0), 64'hFF);
    checkOutput("rst_web", 64'(web0), 64'h1);
    checkOutput("rst_wmask", 64'(wmask0), 64'h0);
    checkOutput("rst_din", 64'(din0), 64'h0);
    checkOutput("rst_addr", 64'(addr0), 64'h0);
    checkOutput("rst_req_ready_noinit", 64'(reqReady2), 64'h0);
    checkOutput("rst_csb_noinit", 64'(csb2), 64'hF);

    // INIT_ZERO=0, 4 banks: ready at once, read of the top address hits bank 3
    rst2 = 1'b0;
    #1;
    checkOutput("noinit_req_ready", 64'(reqReady2), 64'h1);
    checkOutput("noinit_init_done", 64'(initDone2), 64'h1);
    applyStimulus(1'b1, 1'b0, 12'h7FF, 8'h00, 64'h0);
    checkOutput("noinit_rd_csb", 64'(csb2), 64'h7);
    checkOutput("noinit_rd_addr", 64'(addr2), 64'h1FF);
    checkOutput("noinit_rd_web", 64'(web2), 64'h1);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("noinit_resp_valid", 64'(respValid2), 64'h1);
    checkOutput("noinit_resp_rdata", respRdata2, 64'hFEED_0000_0000_0003);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("noinit_resp_valid_drop", 64'(respValid2), 64'h0);
    checkOutput("noinit_resp_rdata_zero", respRdata2, 64'h0);
    rst2 = 1'b1;

    // Default instance: 512-cycle zero-fill sweep
    rst0 = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      checkOutput("init_addr", 64'(addr0), 64'(i));
      if (csb0 != 8'h00 || web0 != 1'b0 || din0 != 32'h0 || wmask0 != 4'hF || reqReady0 != 1'b0)
        bad++;
      applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    end
    checkOutput("init_pins_bad_cycles", 64'(bad), 64'h0);
    checkOutput("init_end_req_ready", 64'(reqReady0), 64'h1);
    checkOutput("init_end_init_done", 64'(initDone0), 64'h1);

    applyStimulus(1'b1, 1'b1, 12'h605, 8'h05, 64'hA5A5_5A5A);
    checkOutput("wr_csb", 64'(csb0), 64'hF7);
    checkOutput("wr_addr", 64'(addr0), 64'h005);
    checkOutput("wr_web", 64'(web0), 64'h0);
    checkOutput("wr_wmask", 64'(wmask0), 64'h5);
    checkOutput("wr_din", 64'(din0), 64'hA5A5_5A5A);
    applyStimulus(1'b1, 1'b1, 12'h605, 8'h00, 64'hFFFF_FFFF);
    checkOutput("wr0_csb", 64'(csb0), 64'hF7);
    checkOutput("wr0_wmask", 64'(wmask0), 64'h0);
    applyStimulus(1'b1, 1'b0, 12'h605, 8'h00, 64'h0);
    checkOutput("rd_csb", 64'(csb0), 64'hF7);
    checkOutput("rd_web", 64'(web0), 64'h1);
    checkOutput("rd_wmask", 64'(wmask0), 64'h0);
    checkOutput("rd_din", 64'(din0), 64'h0);
    checkOutput("wr0_no_resp", 64'(respValid0), 64'h0);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("rd_resp_valid", 64'(respValid0), 64'h1);
    checkOutput("rd_resp_rdata", 64'(respRdata0), 64'h00A5_005A);
    checkOutput("idle_csb", 64'(csb0), 64'hFF);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("rd_resp_valid_drop", 64'(respValid0), 64'h0);
    checkOutput("rd_resp_rdata_zero", 64'(respRdata0), 64'h0);

    // Reset hits while a read is in flight
    applyStimulus(1'b1, 1'b0, 12'h605, 8'h00, 64'h0);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    reqValid = 1'b0;
    #1;
    checkOutput("rstrd_resp_valid", 64'(respValid0), 64'h0);
    checkOutput("rstrd_resp_rdata", 64'(respRdata0), 64'h0);
    checkOutput("rstrd_csb", 64'(csb0), 64'hFF);
    checkOutput("rstrd_req_ready", 64'(reqReady0), 64'h0);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("rstrd_resp_valid_later", 64'(respValid0), 64'h0);

    // OUT_REG instance: reset in the middle of the sweep restarts it
    rst1 = 1'b0;
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("mid_init_addr", 64'(addr1), 64'd200);
    checkOutput("mid_init_csb", 64'(csb1), 64'h00);
    #1;
    rst1 = 1'b1;
    #1;
    checkOutput("mid_rst_csb", 64'(csb1), 64'hFF);
    checkOutput("mid_rst_web", 64'(web1), 64'h1);
    checkOutput("mid_rst_req_ready", 64'(reqReady1), 64'h0);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    rst1 = 1'b0;
    #1;
    checkOutput("restart_addr", 64'(addr1), 64'h0);
    checkOutput("restart_csb", 64'(csb1), 64'h00);
    n = 0;
    while (!initDone1 && n < 600) begin
      applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
      n++;
    end
    checkOutput("restart_init_cycles", 64'(n), 64'd512);

    // Back-to-back reads through the output register
    applyStimulus(1'b1, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("b2b_csb0", 64'(csb1), 64'hFE);
    applyStimulus(1'b1, 1'b0, 12'hE00, 8'h00, 64'h0);
    checkOutput("b2b_csb7", 64'(csb1), 64'h7F);
    checkOutput("b2b_no_early_valid", 64'(respValid1), 64'h0);
    applyStimulus(1'b1, 1'b0, 12'h1FF, 8'h00, 64'h0);
    checkOutput("b2b_csb0_again", 64'(csb1), 64'hFE);
    checkOutput("b2b_valid_a", 64'(respValid1), 64'h1);
    checkOutput("b2b_rdata_a", 64'(respRdata1), 64'hC0DE_0000);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("b2b_valid_b", 64'(respValid1), 64'h1);
    checkOutput("b2b_rdata_b", 64'(respRdata1), 64'hC0DE_0007);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("b2b_valid_c", 64'(respValid1), 64'h1);
    checkOutput("b2b_rdata_c", 64'(respRdata1), 64'hC0DE_0000);
    applyStimulus(1'b0, 1'b0, 12'h000, 8'h00, 64'h0);
    checkOutput("b2b_valid_end", 64'(respValid1), 64'h0);
    checkOutput("b2b_rdata_end", 64'(respRdata1), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
